codprior_rr_reg: RTL and testbench

// - Parametrised N-input priority encoder with a registered output stage.
// - Successor to the fixed 8-to-3 priority encoder. Adds:
//   - arbitrary width N;
//   - a fixed or round-robin priority mode;
//   - a valid/ready handshake on both sides.
// - Sits between request sources and a consumer that needs one winning index per transaction.
//

---
 rtl/codprior_rr_reg.sv | 116 +++++++++++
 tb/tb_codprior_rr_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/codprior_rr_reg.sv
// codprior_rr_reg: N-input priority encoder with a single registered output
// stage and a valid/ready handshake on both sides.
// RR=0 selects fixed priority (highest index wins). RR=1 selects round-robin,
// where the last winner becomes the lowest priority.
// Optional macro CODPRIOR_MASK_EN adds a per-source suppress mask input.
`timescale 1ns/1ps

module codprior_rr_reg #(
  parameter int N  = 8,
  parameter int W  = $clog2(N),
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
`ifdef CODPRIOR_MASK_EN
  input  logic [N-1:0] mask,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         none
);

  // Registered state and next-state values.
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         none_q, none_d;
  logic [W-1:0] ptr_q, ptr_d;

  // Search datapath.
  logic [N-1:0] eff_vec;
  logic [W-1:0] cand [N];
  logic [N-1:0] hit;
  logic         win_found;
  logic [W-1:0] win_idx;
  logic         capture;
  logic         drain;

  // Effective request vector: masked sources drop out before the search.
`ifdef CODPRIOR_MASK_EN
  assign eff_vec = req & ~mask;
`else
  assign eff_vec = req;
`endif

  // Candidate for search slot gi is ptr-gi, wrapped modulo N (not 2^W).
  // In fixed mode ptr stays at N-1, so this same order gives highest-index-first.
  // The wrapped sum ptr+(N-gi) is always < N, so it fits in W bits.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = (ptr_q >= W'(gi)) ? (ptr_q - W'(gi))
                                          : (ptr_q + W'(N - gi));
      assign hit[gi]  = eff_vec[cand[gi]];
    end
  endgenerate

  // Pick the first slot in search order that holds an active request.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && hit[k]) begin
        win_found = 1'b1;
        win_idx   = cand[k];
      end
    end
  end

  // With one output register and no skid buffer, the block can accept a
  // new request whenever the output slot is empty or is draining this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  // Next-state: a capture overwrites the result; a drain alone only clears valid.
  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    none_d      = none_q;
    ptr_d       = ptr_q;
    if (capture) begin
      out_valid_d = 1'b1;
      idx_d       = win_found ? win_idx : '0;
      none_d      = !win_found;
      if ((RR != 0) && win_found) begin
        ptr_d = (win_idx == '0) ? W'(N - 1) : (win_idx - W'(1));
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held result and restores fixed order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      none_q      <= 1'b0;
      ptr_q       <= W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      none_q      <= none_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign none      = none_q;

endmodule

// File: tb/tb_codprior_rr_reg.sv
// Bench for codprior_rr_reg: three instances (fixed N=8, round-robin N=8,
// round-robin N=5) share one stimulus stream. They are compared every cycle
// against a transaction-level reference model.
`timescale 1ns/1ps

module tb_codprior_rr_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] req;
  logic [7:0] mask_r;

  logic [2:0] ir;
  logic [2:0] ov;
  logic [2:0] nn;
  logic [2:0] idx_w [3];

  always #5 clk = ~clk;

  codprior_rr_reg #(.N(8), .RR(0)) u_fix8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .req(req),
`ifdef CODPRIOR_MASK_EN
    .mask(mask_r),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .idx(idx_w[0]), .none(nn[0])
  );

  codprior_rr_reg #(.N(8), .RR(1)) u_rr8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .req(req),
`ifdef CODPRIOR_MASK_EN
    .mask(mask_r),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .idx(idx_w[1]), .none(nn[1])
  );

  codprior_rr_reg #(.N(5), .RR(1)) u_rr5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .req(req[4:0]),
`ifdef CODPRIOR_MASK_EN
    .mask(mask_r[4:0]),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .idx(idx_w[2]), .none(nn[2])
  );

  // Reference model state, one entry per instance.
  int m_n  [3] = '{8, 8, 5};
  int m_rr [3] = '{0, 1, 1};
  bit m_ov   [3];
  int m_idx  [3];
  bit m_none [3];
  int m_ptr  [3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Winner by the spec's rules: fixed = highest set bit; RR = scan ptr downward, wrapping mod N.
  function automatic int pick(input int d, input int e, output bit found);
    int n;
    n = m_n[d];
    found = 1'b0;
    pick = 0;
    if (m_rr[d] == 0) begin
      for (int i = n - 1; i >= 0; i--)
        if (!found && e[i]) begin found = 1'b1; pick = i; end
    end else begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (m_ptr[d] - k + n) % n;
        if (!found && e[c]) begin found = 1'b1; pick = c; end
      end
    end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_ov[d] = 1'b0; m_idx[d] = 0; m_none[d] = 1'b0; m_ptr[d] = m_n[d] - 1;
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready, update model at posedge, check outputs.
  task automatic step(input bit iv, input bit orr, input bit rs,
                      input logic [7:0] rq, input logic [7:0] mk, input bit verbose);
    bit cap;
    @(negedge clk);
    rst = rs; in_valid = iv; out_ready = orr; req = rq; mask_r = mk;
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("in_ready[%0d]", d), {31'd0, ir[d]}, {31'd0, (!m_ov[d] || orr)});
    @(posedge clk);
    cap = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (rs) begin
        m_ov[d] = 1'b0; m_idx[d] = 0; m_none[d] = 1'b0; m_ptr[d] = m_n[d] - 1;
      end else if (iv && (!m_ov[d] || orr)) begin
        int  e;
        int  w;
        bit  f;
        e = int'(rq);
`ifdef CODPRIOR_MASK_EN
        e = int'(rq & ~mk);
`endif
        e = e & ((1 << m_n[d]) - 1);
        w = pick(d, e, f);
        cap = 1'b1;
        m_ov[d] = 1'b1;
        m_none[d] = !f;
        m_idx[d] = f ? w : 0;
        if (f && m_rr[d] != 0) m_ptr[d] = (w == 0) ? m_n[d] - 1 : w - 1;
      end else if (m_ov[d] && orr) begin
        m_ov[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("out_valid[%0d]", d), {31'd0, ov[d]}, {31'd0, m_ov[d]});
      chk($sformatf("idx[%0d]", d), {29'd0, idx_w[d]}, m_idx[d]);
      chk($sformatf("none[%0d]", d), {31'd0, nn[d]}, {31'd0, m_none[d]});
    end
    if (verbose)
      $display("txn rst=%0d iv=%0d ordy=%0d req=%02h cap=%0d | fix8 v=%0d i=%0d n=%0d | rr8 v=%0d i=%0d n=%0d | rr5 v=%0d i=%0d n=%0d",
               rs, iv, orr, rq, cap, ov[0], idx_w[0], nn[0], ov[1], idx_w[1], nn[1],
               ov[2], idx_w[2], nn[2]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; req = '0; mask_r = '0;
    model_reset();

    // Reset state
    step(0, 1, 1, 8'h00, 8'h00, 1);
    step(0, 1, 1, 8'h00, 8'h00, 1);

    // Fixed-priority basics, zero vector, lowest source
    step(1, 1, 0, 8'b0001_0110, 8'h00, 1);
    step(0, 1, 0, 8'h00, 8'h00, 1);
    step(1, 1, 0, 8'h00, 8'h00, 1);
    step(1, 1, 0, 8'h01, 8'h00, 1);
    step(0, 1, 0, 8'h00, 8'h00, 1);

    // Backpressure: hold for 3 cycles, then capture with drain in the same cycle
    step(1, 0, 0, 8'h80, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h3C, 8'h00, 1);
    step(1, 1, 0, 8'h02, 8'h00, 1);
    step(0, 1, 0, 8'h00, 8'h00, 1);

    // Round-robin sequences from a fresh reset
    step(0, 1, 1, 8'h00, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 8'b1000_0001, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'hFF, 8'h00, 1);
    step(0, 1, 1, 8'h00, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 8'h03, 8'h00, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 8'h1F, 8'h00, 1);

    // Reset while a result is held under backpressure
    step(1, 0, 0, 8'h55, 8'h00, 1);
    step(0, 0, 0, 8'h00, 8'h00, 1);
    step(1, 0, 1, 8'hAA, 8'h00, 1);
    step(0, 1, 0, 8'h00, 8'h00, 1);

    // Mask suppresses the otherwise-winning source
    step(1, 1, 0, 8'h81, 8'h80, 1);
    step(0, 1, 0, 8'h00, 8'h00, 1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rq;
      logic [7:0] mk;
      case ($urandom_range(0, 3))
        0:       rq = 8'h00;
        1:       rq = 8'(1 << $urandom_range(0, 7));
        default: rq = 8'($urandom);
      endcase
      mk = 8'($urandom & $urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0, rq, mk, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
